// File: rtl/qrs_beat_detector.sv
// rtl/qrs_beat_detector.sv - adaptive-threshold QRS detector with R-R to BPM divider
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   en         sample strobe; din is consumed when high
//   din        signed integrator output sample (NBIT)
//   beat       one-cycle pulse per confirmed QRS
//   bpm        last computed heart rate (0 after a timeout)
//   bpm_valid  one-cycle pulse when bpm updates
//   busy       sequential divider running
module qrs_beat_detector #(
    parameter int NBIT    = 16,
    parameter int FS      = 200,
    parameter int TH_INIT = 1024,
    parameter int REFRACT = 40,
    parameter int CNT_W   = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic signed [NBIT-1:0] din,
    output logic                   beat,
    output logic [7:0]             bpm,
    output logic                   bpm_valid,
    output logic                   busy
);

    localparam int DW = 17;
    localparam int RW = $clog2(REFRACT + 1);
    localparam logic [15:0]      DIVIDEND = 16'(60 * FS);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {SEARCH, PEAK, REFR} state_t;

    state_t                 state_q, state_d;
    logic signed [NBIT-1:0] peak_q, peak_d;
    logic [RW-1:0]          ref_q, ref_d;
    logic signed [NBIT:0]   spk;
    logic [NBIT-1:0]        th;
    logic [CNT_W-1:0]       cnt;
    logic                   have_prev;
    logic                   confirm;

    logic signed [NBIT:0]   din_x, th_x, peak_x, spk_next;
    logic                   din_gt_th, din_lt_th;
    logic [CNT_W:0]         rr;
    logic                   timeout, start;

    logic [DW-1:0]          rem, dsr, rem_sh, diff;
    logic [15:0]            quo;
    logic [4:0]             div_cnt;

    // th is always half the running peak estimate, zero-extended for the signed compare
    assign th        = spk[NBIT:1];
    assign din_x     = {din[NBIT-1], din};
    assign th_x      = {1'b0, th};
    assign peak_x    = {peak_q[NBIT-1], peak_q};
    assign din_gt_th = din_x > th_x;
    assign din_lt_th = din_x < th_x;
    assign spk_next  = spk - (spk >>> 3) + (peak_x >>> 3);

    assign rr      = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    // A confirmation on the saturating sample suppresses the timeout
    assign timeout = en && !confirm && (cnt == CNT_MAX - 1'b1);
    assign start   = confirm && have_prev;

    assign rem_sh  = {rem[DW-2:0], quo[15]};
    assign diff    = rem_sh - dsr;

    always_comb begin
        state_d = state_q;
        peak_d  = peak_q;
        ref_d   = ref_q;
        confirm = 1'b0;
        if (en) begin
            case (state_q)
                SEARCH: begin
                    if (din_gt_th) begin
                        peak_d  = din;
                        state_d = PEAK;
                    end
                end
                PEAK: begin
                    if (din >= peak_q) peak_d = din;
                    if (din_lt_th) begin
                        confirm = 1'b1;
                        ref_d   = RW'(REFRACT);
                        state_d = REFR;
                    end
                end
                REFR: begin
                    ref_d = ref_q - 1'b1;
                    if (ref_q == RW'(1)) state_d = SEARCH;
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEARCH;
            peak_q  <= '0;
            ref_q   <= '0;
            spk     <= (NBIT+1)'(2 * TH_INIT);
            cnt     <= '0;
            have_prev <= 1'b0;
            beat    <= 1'b0;
        end else begin
            state_q <= state_d;
            peak_q  <= peak_d;
            ref_q   <= ref_d;
            beat    <= confirm;
            if (confirm) spk <= spk_next;
            if (en) begin
                if (confirm)             cnt <= '0;
                else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end
            if (confirm)      have_prev <= 1'b1;
            else if (timeout) have_prev <= 1'b0;
        end
    end

    // Restoring divider: 16 quotient bits on the clocks after start, result
    // registered on the 17th clock. A new start simply reloads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem       <= '0;
            dsr       <= '0;
            quo       <= '0;
            div_cnt   <= '0;
            busy      <= 1'b0;
            bpm       <= '0;
            bpm_valid <= 1'b0;
        end else begin
            bpm_valid <= 1'b0;
            if (start) begin
                rem     <= '0;
                quo     <= DIVIDEND;
                dsr     <= DW'(rr);
                div_cnt <= 5'd16;
                busy    <= 1'b1;
            end else if (busy) begin
                if (div_cnt != 5'd0) begin
                    if (rem_sh >= dsr) begin
                        rem <= diff;
                        quo <= {quo[14:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        quo <= {quo[14:0], 1'b0};
                    end
                    div_cnt <= div_cnt - 1'b1;
                end else begin
                    bpm       <= (|quo[15:8]) ? 8'hFF : quo[7:0];
                    bpm_valid <= 1'b1;
                    busy      <= 1'b0;
                end
            end
            if (timeout) begin
                bpm       <= '0;
                bpm_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qrs_beat_detector.sv
// tb/tb_qrs_beat_detector.sv - directed self-checking bench for qrs_beat_detector
module tb_qrs_beat_detector;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en  = 1'b0;
    logic signed [15:0] din = '0;
    logic               beat, bpm_valid, busy;
    logic [7:0]         bpm;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int beat_cnt = 0, valid_cnt = 0, beat_cyc = 0, valid_cyc = 0;
    int last_bpm = -1;
    int b0, v0;

    qrs_beat_detector dut (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .beat(beat), .bpm(bpm), .bpm_valid(bpm_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (beat === 1'b1) begin
            beat_cnt = beat_cnt + 1;
            beat_cyc = cyc;
        end
        if (bpm_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
            last_bpm  = int'(bpm);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic smp(input logic e, input logic signed [15:0] d);
        @(negedge clk);
        en  = e;
        din = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b0; din = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) smp(1'b0, 16'sd0);
    endtask

    // One sparse sample: en high for one clk out of four
    task automatic ssmp(input logic signed [15:0] d);
        smp(1'b1, d);
        smp(1'b0, 16'sd0);
        smp(1'b0, 16'sd0);
        smp(1'b0, 16'sd0);
    endtask

    initial begin
        // reset with a large input present
        @(negedge clk);
        rst = 1'b0; en = 1'b1; din = 16'sd5000;
        repeat (3) @(negedge clk);
        check("rst_beat", beat, 0);
        check("rst_bpm", bpm, 0);
        check("rst_valid", bpm_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1; din = '0;

        // idle then timeout
        b0 = beat_cnt; v0 = valid_cnt;
        for (int k = 1; k <= 4094; k++) smp(1'b1, 16'sd0);
        smp(1'b1, 16'sd0);
        check("idle_beats", beat_cnt - b0, 0);
        check("idle_valid", valid_cnt - v0, 0);
        idle(2);
        check("tmo_valid", valid_cnt - v0, 1);
        check("tmo_bpm", last_bpm, 0);
        for (int k = 0; k < 20; k++) smp(1'b1, 16'sd0);
        check("tmo_once", valid_cnt - v0, 1);

        // two pulses 200 samples apart
        do_reset();
        b0 = beat_cnt; v0 = valid_cnt;
        for (int k = 1; k <= 330; k++) begin
            smp(1'b1, (k == 98 || k == 99 || k == 298 || k == 299) ? 16'sd3000 : 16'sd0);
            if (k == 101) begin
                check("first_beat_pulse", beat, 1);
                check("first_no_busy", busy, 0);
            end
            if (k == 301) begin
                check("second_beat_pulse", beat, 1);
                check("second_busy", busy, 1);
            end
        end
        check("two_beats", beat_cnt - b0, 2);
        check("two_valid", valid_cnt - v0, 1);
        check("bpm_60", last_bpm, 60);
        check("latency", valid_cyc - beat_cyc, 17);
        check("busy_done", busy, 0);

        // threshold adapts to 1083: 1050 and 1083 miss, 1084 detects
        do_reset();
        b0 = beat_cnt;
        for (int k = 1; k <= 200; k++) begin
            logic signed [15:0] d;
            d = 16'sd0;
            if (k == 98 || k == 99) d = 16'sd3000;
            if (k == 150 || k == 151) d = 16'sd1050;
            if (k == 160) d = 16'sd1083;
            if (k == 170) d = 16'sd1084;
            smp(1'b1, d);
            if (k == 165) check("th_below", beat_cnt - b0, 1);
        end
        check("th_above", beat_cnt - b0, 2);

        // refractory: excursions at +30 and +40 ignored, confirmation at +45 counts
        do_reset();
        b0 = beat_cnt; v0 = valid_cnt;
        for (int k = 1; k <= 200; k++) begin
            logic signed [15:0] d;
            d = 16'sd0;
            if (k == 98 || k == 99) d = 16'sd3000;
            if (k == 130 || k == 140) d = 16'sd4000;
            if (k == 143 || k == 144) d = 16'sd4000;
            smp(1'b1, d);
        end
        check("refr_beats", beat_cnt - b0, 2);
        check("refr_valid", valid_cnt - v0, 1);
        check("bpm_sat", last_bpm, 255);

        // sparse en: 100 samples apart -> 120 bpm
        do_reset();
        b0 = beat_cnt; v0 = valid_cnt;
        for (int k = 1; k <= 200; k++)
            ssmp((k == 98 || k == 99 || k == 198 || k == 199) ? 16'sd3000 : 16'sd0);
        idle(20);
        check("sparse_beats", beat_cnt - b0, 2);
        check("sparse_valid", valid_cnt - v0, 1);
        check("bpm_120", last_bpm, 120);
        check("sparse_latency", valid_cyc - beat_cyc, 17);

        // third beat, then reset 5 clk later in the middle of its division
        for (int k = 201; k <= 300; k++) begin
            if (k == 300) smp(1'b1, 16'sd0);
            else          ssmp((k == 298 || k == 299) ? 16'sd3000 : 16'sd0);
        end
        idle(5);
        check("mid_busy", busy, 1);
        do_reset();
        v0 = valid_cnt;
        idle(40);
        check("abort_valid", valid_cnt - v0, 0);
        check("abort_busy", busy, 0);
        check("abort_bpm", bpm, 0);
        check("third_beat", beat_cnt - b0, 3);

        // first beat after reset: no division
        b0 = beat_cnt;
        for (int k = 1; k <= 110; k++)
            ssmp((k == 98 || k == 99) ? 16'sd3000 : 16'sd0);
        idle(30);
        check("post_rst_beat", beat_cnt - b0, 1);
        check("post_rst_valid", valid_cnt - v0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
